// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control FSM.
// EXEC_I keeps its encoding in every build; it is only reachable with MC_CTRL_ITYPE_EN.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_HALT     = 4'd9,
        S_EXEC_I   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_OFF  = 2'b11;

    // Last state of every retiring instruction; the next edge returns to FETCH.
    function automatic logic is_terminal(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) || (s == S_BRANCH);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> datapath control decoder (Moore outputs).
// EXEC_I decoding is present only when MC_CTRL_ITYPE_EN is defined.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_alu_src_b,
    output logic       o_alu_src_a,
    output logic       o_pc_source,
    output logic       o_mem_to_reg,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_i_or_d,
    output logic       o_reg_write,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_pc_write_cond
);

    always_comb begin
        o_alu_op        = ALUOP_ADD;
        o_alu_src_b     = SRCB_B;
        o_alu_src_a     = 1'b0;
        o_pc_source     = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_i_or_d        = 1'b0;
        o_reg_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_ir_write  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_pc_write  = 1'b1;
            end
            S_DECODE:   o_alu_src_b = SRCB_OFF;
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                o_mem_write = 1'b1;
                o_i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    o_reg_write = 1'b1;
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = 1'b1;
            end
`ifdef MC_CTRL_ITYPE_EN
            S_EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RISC-V datapath with a retired-instruction counter.
// Define MC_CTRL_ITYPE_EN to add the addi path (DECODE -> EXEC_I -> ALUWB).
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       opcode,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic             ALUSrcA,
    output logic             PCSource,
    output logic             MemtoReg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             RegWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;

    logic [1:0] w_alu_op, w_alu_src_b;
    logic       w_alu_src_a, w_pc_source, w_mem_to_reg, w_mem_read, w_mem_write;
    logic       w_i_or_d, w_reg_write, w_ir_write, w_pc_write, w_pc_write_cond;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LD, OP_SD: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC_R;
                    OP_BEQ:       w_next = S_BRANCH;
`ifdef MC_CTRL_ITYPE_EN
                    OP_ITYPE:     w_next = S_EXEC_I;
`endif
                    default:      w_next = S_HALT;
                endcase
            end
            // Opcode is re-sampled here; anything but LD/SD at this point is treated as illegal.
            S_MEMADR: begin
                if (opcode == OP_LD)      w_next = S_MEMREAD;
                else if (opcode == OP_SD) w_next = S_MEMWRITE;
                else                      w_next = S_HALT;
            end
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXEC_R:   w_next = S_ALUWB;
`ifdef MC_CTRL_ITYPE_EN
            S_EXEC_I:   w_next = S_ALUWB;
`endif
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_HALT;
        endcase
    end

    // An instruction interrupted by reset in its last cycle is abandoned, not retired.
    always_ff @(posedge clock) begin
        if (reset)                    r_instret <= '0;
        else if (is_terminal(r_state)) r_instret <= r_instret + CNT_W'(1);
    end

    mc_ctrl_outdec u_outdec (
        .i_state         (r_state),
        .o_alu_op        (w_alu_op),
        .o_alu_src_b     (w_alu_src_b),
        .o_alu_src_a     (w_alu_src_a),
        .o_pc_source     (w_pc_source),
        .o_mem_to_reg    (w_mem_to_reg),
        .o_mem_read      (w_mem_read),
        .o_mem_write     (w_mem_write),
        .o_i_or_d        (w_i_or_d),
        .o_reg_write     (w_reg_write),
        .o_ir_write      (w_ir_write),
        .o_pc_write      (w_pc_write),
        .o_pc_write_cond (w_pc_write_cond)
    );

    always_comb begin
        ALUOp       = reset ? 2'b00 : w_alu_op;
        ALUSrcB     = reset ? 2'b00 : w_alu_src_b;
        ALUSrcA     = w_alu_src_a     & ~reset;
        PCSource    = w_pc_source     & ~reset;
        MemtoReg    = w_mem_to_reg    & ~reset;
        MemRead     = w_mem_read      & ~reset;
        MemWrite    = w_mem_write     & ~reset;
        IorD        = w_i_or_d        & ~reset;
        RegWrite    = w_reg_write     & ~reset;
        IRWrite     = w_ir_write      & ~reset;
        PCWrite     = w_pc_write      & ~reset;
        PCWriteCond = w_pc_write_cond & ~reset;
    end

    assign state   = r_state;
    assign halted  = (r_state == S_HALT);
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; uses a 3-bit counter so wraparound is reachable.
// Covers the addi path when MC_CTRL_ITYPE_EN is defined, otherwise checks it halts.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    localparam int CNT_W = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic [6:0]       opcode;
    logic [1:0]       ALUOp, ALUSrcB;
    logic             ALUSrcA, PCSource, MemtoReg, MemRead, MemWrite, IorD;
    logic             RegWrite, IRWrite, PCWrite, PCWriteCond;
    logic [3:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instret;

    int total = 0;
    int bad   = 0;

    // {ALUOp, ALUSrcB, ALUSrcA, PCSource, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond}
    localparam logic [13:0] C_ZERO     = {2'b00, 2'b00, 10'b0000000000};
    localparam logic [13:0] C_FETCH    = {2'b00, 2'b01, 10'b0001000110};
    localparam logic [13:0] C_DECODE   = {2'b00, 2'b11, 10'b0000000000};
    localparam logic [13:0] C_MEMADR   = {2'b00, 2'b10, 10'b1000000000};
    localparam logic [13:0] C_MEMREAD  = {2'b00, 2'b00, 10'b0001010000};
    localparam logic [13:0] C_MEMWB    = {2'b00, 2'b00, 10'b0010001000};
    localparam logic [13:0] C_MEMWRITE = {2'b00, 2'b00, 10'b0000110000};
    localparam logic [13:0] C_EXEC_R   = {2'b10, 2'b00, 10'b1000000000};
    localparam logic [13:0] C_ALUWB    = {2'b00, 2'b00, 10'b0000001000};
    localparam logic [13:0] C_BRANCH   = {2'b01, 2'b00, 10'b1100000001};
    localparam logic [13:0] C_EXEC_I   = {2'b00, 2'b10, 10'b1000000000};

    logic [13:0] ctrl;
    assign ctrl = {ALUOp, ALUSrcB, ALUSrcA, PCSource, MemtoReg, MemRead, MemWrite,
                   IorD, RegWrite, IRWrite, PCWrite, PCWriteCond};

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
        .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .state(state), .halted(halted), .instret(instret)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_st(input string tag, input state_t s, input logic [13:0] c,
                             input int n);
        check({tag, ".state"},   32'(state),   32'(s));
        check({tag, ".ctrl"},    32'(ctrl),    32'(c));
        check({tag, ".instret"}, 32'(instret), 32'(n));
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 7'b0;

        // Reset held two cycles: outputs gated to zero, state/counter initialised.
        tick();
        expect_st("rst1", S_FETCH, C_ZERO, 0);
        check("rst1.halted", 32'(halted), 32'(0));
        tick();
        expect_st("rst2", S_FETCH, C_ZERO, 0);
        reset = 1'b0;
        #1;
        expect_st("fetch0", S_FETCH, C_FETCH, 0);

        // LD: 5 cycles
        opcode = OP_LD;
        tick(); expect_st("ld.dec",   S_DECODE,  C_DECODE,  0);
        tick(); expect_st("ld.adr",   S_MEMADR,  C_MEMADR,  0);
        tick(); expect_st("ld.rd",    S_MEMREAD, C_MEMREAD, 0);
        tick(); expect_st("ld.wb",    S_MEMWB,   C_MEMWB,   0);
        tick(); expect_st("ld.fetch", S_FETCH,   C_FETCH,   1);

        // SD: 4 cycles
        opcode = OP_SD;
        tick(); expect_st("sd.dec",   S_DECODE,   C_DECODE,   1);
        tick(); expect_st("sd.adr",   S_MEMADR,   C_MEMADR,   1);
        tick(); expect_st("sd.wr",    S_MEMWRITE, C_MEMWRITE, 1);
        tick(); expect_st("sd.fetch", S_FETCH,    C_FETCH,    2);

        // BEQ then R-type
        opcode = OP_BEQ;
        tick(); expect_st("beq.dec",   S_DECODE, C_DECODE, 2);
        tick(); expect_st("beq.br",    S_BRANCH, C_BRANCH, 2);
        opcode = 7'b1111111;   // don't-care outside DECODE/MEMADR
        tick(); expect_st("beq.fetch", S_FETCH,  C_FETCH,  3);
        opcode = OP_RTYPE;
        tick(); expect_st("r.dec",   S_DECODE, C_DECODE, 3);
        tick(); expect_st("r.exec",  S_EXEC_R, C_EXEC_R, 3);
        tick(); expect_st("r.wb",    S_ALUWB,  C_ALUWB,  3);
        tick(); expect_st("r.fetch", S_FETCH,  C_FETCH,  4);

        // Illegal opcode halts, nothing retires, reset recovers.
        opcode = 7'b1111111;
        tick(); expect_st("ill.dec", S_DECODE, C_DECODE, 4);
        check("ill.dec.halted", 32'(halted), 32'(0));
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_st("ill.halt", S_HALT, C_ZERO, 4);
            check("ill.halted", 32'(halted), 32'(1));
        end
        reset = 1'b1;
        tick(); expect_st("ill.rst", S_FETCH, C_ZERO, 0);
        check("ill.rst.halted", 32'(halted), 32'(0));
        reset = 1'b0;
        #1; expect_st("ill.rec", S_FETCH, C_FETCH, 0);

        // Reset during MEMREAD: controls gated, no RegWrite, back to FETCH.
        opcode = OP_LD;
        tick(); expect_st("mid.dec", S_DECODE,  C_DECODE,  0);
        tick(); expect_st("mid.adr", S_MEMADR,  C_MEMADR,  0);
        tick(); expect_st("mid.rd",  S_MEMREAD, C_MEMREAD, 0);
        reset = 1'b1;
        #1; check("mid.gate", 32'(ctrl), 32'(C_ZERO));
        tick(); expect_st("mid.rst", S_FETCH, C_ZERO, 0);
        check("mid.regwrite", 32'(RegWrite), 32'(0));
        reset = 1'b0;
        #1; expect_st("mid.rec", S_FETCH, C_FETCH, 0);

        // Eight BEQs wrap the 3-bit counter back to zero.
        opcode = OP_BEQ;
        for (int i = 1; i <= 8; i++) begin
            tick(); tick(); tick();
            expect_st("wrap", S_FETCH, C_FETCH, i % 8);
        end

        // addi opcode
        opcode = OP_ITYPE;
        tick(); expect_st("addi.dec", S_DECODE, C_DECODE, 0);
`ifdef MC_CTRL_ITYPE_EN
        tick(); expect_st("addi.exec",  S_EXEC_I, C_EXEC_I, 0);
        tick(); expect_st("addi.wb",    S_ALUWB,  C_ALUWB,  0);
        tick(); expect_st("addi.fetch", S_FETCH,  C_FETCH,  1);
`else
        tick(); expect_st("addi.halt", S_HALT, C_ZERO, 0);
        check("addi.halted", 32'(halted), 32'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
